// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run/done initiator: state encodings and default widths.
// Optional watchdog is enabled by defining RUN_SEQ_TIMEOUT_EN.
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUE  = 2'b01,
    S_WAIT   = 2'b10,
    S_FINISH = 2'b11
  } state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TMO_CYC = 16;
  localparam int DEF_TMO_W   = 5;

endpackage

// File: rtl/run_sequencer_wdt.sv
// Watchdog for run_sequencer: counts consecutive waiting cycles, flags the TMO_CYC-th one.
// Compiled only when RUN_SEQ_TIMEOUT_EN is defined.
`ifdef RUN_SEQ_TIMEOUT_EN
module run_seq_wdt #(
  parameter int TMO_CYC = 16,
  parameter int TMO_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  // r_cnt holds the number of silent cycles already seen, so this is the TMO_CYC-th one
  assign expire = en && (r_cnt == TMO_W'(TMO_CYC - 1));

endmodule
`endif

// File: rtl/run_sequencer.sv
// Initiator of the run/done handshake: issues N run pulses, one per worker done.
// Define RUN_SEQ_TIMEOUT_EN to add the S_WAIT watchdog and the sticky o_error flag.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_CYC = DEF_TMO_CYC,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num,
  input  logic             i_done,
  output logic             o_run,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_finish,
  output logic             o_error
);

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef RUN_SEQ_TIMEOUT_EN
  logic r_error;
  logic w_expire;

  run_seq_wdt #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_wdt (
    .clk    (clk),
    .reset  (reset),
    .clr    (r_state == S_ISSUE),
    .en     ((r_state == S_WAIT) && !i_done),
    .expire (w_expire)
  );

  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_cnt   <= '0;
`ifdef RUN_SEQ_TIMEOUT_EN
      r_error <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cnt <= '0;
`ifdef RUN_SEQ_TIMEOUT_EN
            r_error <= 1'b0;
`endif
            if (i_num != '0) begin
              r_num   <= i_num;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_FINISH;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // A done arriving in the watchdog expiry cycle takes priority
          if (i_done) begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc == r_num) ? S_FINISH : S_ISSUE;
          end
`ifdef RUN_SEQ_TIMEOUT_EN
          else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= S_FINISH;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_run    = (r_state == S_ISSUE);
  assign o_busy   = (r_state != S_IDLE);
  assign o_finish = (r_state == S_FINISH);
  assign o_cnt    = r_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed-plus-random bench for run_sequencer; expected per-cycle outputs come from a
// timeline model built from run count and per-run worker latencies.
module tb_run_sequencer;

  localparam int CNT_W = 8;
  localparam int TMO   = 16;
  localparam int MAXC  = 160;
  localparam int SILENT = 999;
`ifdef RUN_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             i_start;
  logic [CNT_W-1:0] i_num;
  logic             i_done;
  logic             o_run;
  logic             o_busy;
  logic [CNT_W-1:0] o_cnt;
  logic             o_finish;
  logic             o_error;

  int checks = 0;
  int failures = 0;
  int prev_cnt = 0;
  bit prev_err = 1'b0;
  int dly[8];

  run_sequencer #(.CNT_W(CNT_W), .TMO_CYC(TMO), .TMO_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_start  (i_start),
    .i_num    (i_num),
    .i_done   (i_done),
    .o_run    (o_run),
    .o_busy   (o_busy),
    .o_cnt    (o_cnt),
    .o_finish (o_finish),
    .o_error  (o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit run, input bit busy, input bit fin,
                         input int cnt, input bit err);
    chk({tag, ".run"}, 32'(o_run), 32'(run));
    chk({tag, ".busy"}, 32'(o_busy), 32'(busy));
    chk({tag, ".finish"}, 32'(o_finish), 32'(fin));
    chk({tag, ".cnt"}, 32'(o_cnt), 32'(cnt));
    chk({tag, ".error"}, 32'(o_error), 32'(err));
  endtask

  // Job starts with i_start in cycle 0; run i is issued, waited on for dly[i] cycles
  // (done in the last of them), then the next run follows immediately.
  task automatic run_job(input string name, input int n, input int d[8], input bit stray,
                         input int stop_c);
    bit run_e[MAXC];
    bit wait_e[MAXC];
    bit done_d[MAXC];
    int cnt_e[MAXC];
    int c = 1;
    int cnt = 0;
    bit err = 1'b0;
    int f;
    for (int k = 0; k < MAXC; k++) begin
      run_e[k] = 0; wait_e[k] = 0; done_d[k] = 0; cnt_e[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      run_e[c] = 1; cnt_e[c] = cnt;
      if (TMO_EN && d[i] > TMO) begin
        for (int k = 1; k <= TMO; k++) begin wait_e[c+k] = 1; cnt_e[c+k] = cnt; end
        c = c + TMO + 1;
        err = 1'b1;
        break;
      end
      for (int k = 1; k <= d[i]; k++) begin wait_e[c+k] = 1; cnt_e[c+k] = cnt; end
      done_d[c + d[i]] = 1;
      cnt++;
      c = c + d[i] + 1;
    end
    f = c;
    cnt_e[f] = cnt;
    for (int cy = 0; cy <= f && cy < stop_c; cy++) begin
      @(posedge clk); #1;
      if (cy == 0) begin
        chk_all($sformatf("%s.c0", name), 0, 0, 0, prev_cnt, prev_err);
        i_start = 1'b1;
        i_num   = CNT_W'(n);
        i_done  = stray ? 1'($urandom_range(1)) : 1'b0;
      end else begin
        chk_all($sformatf("%s.c%0d", name, cy), run_e[cy], 1, (cy == f),
                cnt_e[cy], (cy == f) ? err : 1'b0);
        i_start = stray ? 1'($urandom_range(1)) : 1'b0;
        i_num   = CNT_W'($urandom);
        i_done  = wait_e[cy] ? done_d[cy] : (stray ? 1'($urandom_range(1)) : 1'b0);
      end
    end
    if (stop_c > f) begin
      prev_cnt = cnt;
      prev_err = err;
    end
    $display("job %s n=%0d finish_cycle=%0d cnt=%0d err=%0d", name, n, f, cnt, err);
  endtask

  task automatic idle_cycle(input string name);
    @(posedge clk); #1;
    chk_all(name, 0, 0, 0, prev_cnt, prev_err);
    i_start = 1'b0;
    i_done  = 1'b0;
    $display("idle %s cnt=%0d", name, prev_cnt);
  endtask

  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    i_num   = '0;
    i_done  = 1'b0;

    // 1: reset held three cycles, then released
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("reset.c%0d", k), 0, 0, 0, 0, 0);
    end
    reset = 1'b0;
    idle_cycle("after_reset");

    // 2: N=3 with two-cycle worker
    for (int k = 0; k < 8; k++) dly[k] = 2;
    run_job("n3", 3, dly, 1'b0, MAXC);
    // 3: N=0, accepted back-to-back
    run_job("n0", 0, dly, 1'b0, MAXC);
    idle_cycle("after_n0");

    // 4: stray start/done around a job, then randomized jobs
    run_job("stray_n4", 4, dly, 1'b1, MAXC);
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 8; k++) dly[k] = $urandom_range(4, 1);
      run_job($sformatf("rand%0d", j), $urandom_range(6), dly, 1'b1, MAXC);
    end
    idle_cycle("after_rand");

`ifdef RUN_SEQ_TIMEOUT_EN
    // 5: worker silent after run 1, then done exactly in the expiry cycle
    for (int k = 0; k < 8; k++) dly[k] = 2;
    dly[1] = SILENT;
    run_job("tmo", 4, dly, 1'b0, MAXC);
    idle_cycle("after_tmo");
    dly[1] = TMO;
    run_job("tmo_edge", 4, dly, 1'b0, MAXC);
    idle_cycle("after_tmo_edge");
`endif

    // 6: reset during the first wait cycle of run 2 of 5
    for (int k = 0; k < 8; k++) dly[k] = 2;
    run_job("abort", 5, dly, 1'b0, 6);
    reset = 1'b1;
    #1;
    chk_all("abort.async", 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all($sformatf("abort.hold%0d", k), 0, 0, 0, 0, 0);
      i_done = 1'b0;
      i_start = 1'b0;
    end
    reset = 1'b0;
    prev_cnt = 0;
    prev_err = 1'b0;
    idle_cycle("abort.idle");
    run_job("after_abort", 2, dly, 1'b0, MAXC);
    idle_cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
